load_use_scoreboard: RTL and testbench

- Parametrised successor of the single-cycle load-use hazard detector for the 16-bit pipelined core.
- Sits at the ID stage. Holds a per-register countdown scoreboard of in-flight load destinations, so memory latencies longer than one cycle are supported.
- Stalls ID/IF and requests an EX bubble while any source register of the ID instruction is still pending.
- LOAD_LAT=1 reproduces the legacy one-stall behaviour.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/inst_src_decode.sv | 39 +++
 rtl/load_use_scoreboard.sv | 84 ++++++++
 tb/tb_load_use_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared decode constants and types for the ID-stage hazard logic.
// Consumed by the load-use scoreboard and by the forwarding unit.
package hazard_pkg;

  localparam logic [1:0] OPC_LD  = 2'b00;
  localparam logic [1:0] OPC_ST  = 2'b01;
  localparam logic [1:0] OPC_BR  = 2'b10;
  localparam logic [1:0] OPC_ALU = 2'b11;

  localparam logic [3:0] ALU_MAX  = 4'd6;
  localparam logic [3:0] OUT      = 4'd13;
  localparam logic [3:0] SHIFT_LO = 4'd8;
  localparam logic [3:0] SHIFT_HI = 4'd11;

  typedef struct packed {
    logic rd_ra;
    logic rd_rb;
    logic wr_ra;
  } src_use_t;

endpackage

// File: rtl/inst_src_decode.sv
// Combinational register-usage decode of a 16-bit instruction word.
// Zero latency; no flow control.
module inst_src_decode
  import hazard_pkg::*;
(
  input  logic [15:0] inst_i,
  output src_use_t    use_o
);

  logic [3:0] op3;
  logic       unused_bits;

  assign op3         = inst_i[7:4];
  assign unused_bits = ^inst_i[2:0];

  always_comb begin
    use_o = '0;
    unique case (inst_i[15:14])
      OPC_ALU: begin
        if (op3 <= ALU_MAX) begin
          use_o.rd_rb = 1'b1;
          // inst[3] selects the immediate form, which has no ra operand
          use_o.rd_ra = ~inst_i[3];
        end else if (op3 == OUT) begin
          use_o.rd_ra = 1'b1;
        end else if (op3 >= SHIFT_LO && op3 <= SHIFT_HI) begin
          use_o.rd_rb = 1'b1;
        end
      end
      OPC_LD: begin
        use_o.rd_rb = 1'b1;
        use_o.wr_ra = 1'b1;
      end
      OPC_ST:  use_o.rd_ra = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// ID-stage load-use hazard detector with a per-register countdown of in-flight loads.
// Optional 32-bit stall counter when HAZARD_PERF_CNT_EN is defined.
module load_use_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [15:0]                id_inst,
  input  logic                       id_flush,
  output logic                       stall,
  output logic                       ex_bubble,
  output logic [2**REG_ADDR_W-1:0]   busy_vec
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int NREG  = 2 ** REG_ADDR_W;
  localparam int CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

  src_use_t                src;
  logic [REG_ADDR_W-1:0]   ra;
  logic [REG_ADDR_W-1:0]   rb;
  logic                    id_req;
  logic                    issue_ld;
  logic [CNT_W-1:0]        cnt_q [NREG];
  logic [CNT_W-1:0]        cnt_d [NREG];

  inst_src_decode u_dec (
    .inst_i (id_inst),
    .use_o  (src)
  );

  assign ra = REG_ADDR_W'(id_inst[13:11]);
  assign rb = REG_ADDR_W'(id_inst[10:8]);

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = (LOAD_LAT != 0) && (cnt_q[r] != '0);
    end
  end

  assign id_req    = id_valid & ~id_flush;
  assign stall     = id_req & ((src.rd_ra & busy_vec[ra]) | (src.rd_rb & busy_vec[rb]));
  assign ex_bubble = stall;
  assign issue_ld  = id_req & ~stall & src.wr_ra;

  // A new load to a pending register reloads it: the youngest load wins
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_ld && (ra == REG_ADDR_W'(r))) begin
        cnt_d[r] = CNT_W'(LOAD_LAT);
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst) cnt_q[r] <= '0;
      else     cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)        perf_q <= '0;
    else if (stall) perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench: four scoreboards (LOAD_LAT 0..3) on shared stimulus; one is selected per scenario.
module tb_load_use_scoreboard;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [15:0] id_inst = '0;
  logic        id_flush = 1'b0;
  logic        st [4];
  logic        ex [4];
  logic [7:0]  bv [4];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] pc [4];
`endif

  int ncmp = 0;
  int nerr = 0;
  int sel  = 1;

  typedef struct {
    logic       s;
    logic [7:0] b;
    string      tag;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    load_use_scoreboard #(.REG_ADDR_W(3), .LOAD_LAT(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .id_valid  (id_valid),
      .id_inst   (id_inst),
      .id_flush  (id_flush),
      .stall     (st[g]),
      .ex_bubble (ex[g]),
      .busy_vec  (bv[g])
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cnt (pc[g])
`endif
    );
  end

  function automatic logic [15:0] ld(input int ra, input int rb);
    return {OPC_LD, 3'(ra), 3'(rb), 8'h00};
  endfunction

  function automatic logic [15:0] alu(input int op3, input int ra, input int rb, input logic imm);
    return {OPC_ALU, 3'(ra), 3'(rb), 4'(op3), imm, 3'b000};
  endfunction

  function automatic logic [15:0] stw(input int ra);
    return {OPC_ST, 3'(ra), 3'd0, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID cycle, queue its expected outputs, compare mid-cycle.
  task automatic cyc(input logic v, input logic [15:0] inst, input logic f,
                     input logic es, input logic [7:0] eb, input string tag);
    exp_t e;
    id_valid = v;
    id_inst  = inst;
    id_flush = f;
    q.push_back('{s: es, b: eb, tag: tag});
    @(negedge clk);
    e = q.pop_front();
    chk({e.tag, ".stall"}, 32'(st[sel]), 32'(e.s));
    chk({e.tag, ".bubble"}, 32'(ex[sel]), 32'(e.s));
    chk({e.tag, ".busy"}, 32'(bv[sel]), 32'(e.b));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    id_valid = 1'b0;
    id_flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst%0d.stall", g), 32'(st[g]), 32'd0);
      chk($sformatf("rst%0d.busy", g), 32'(bv[g]), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
`ifdef HAZARD_PERF_CNT_EN
    for (int g = 0; g < 4; g++) chk($sformatf("perf_rst%0d", g), pc[g], 32'd0);
`endif

    // LOAD_LAT=1 legacy single stall
    sel = 1;
    cyc(1, ld(3, 1), 0, 0, 8'h00, "l1_ld");
    cyc(1, alu(0, 2, 3, 0), 0, 1, 8'h08, "l1_add_stall");
    cyc(1, alu(0, 2, 3, 0), 0, 0, 8'h00, "l1_add_issue");

    // LOAD_LAT=3 immediate dependent
    do_reset();
    sel = 3;
    cyc(1, ld(5, 0), 0, 0, 8'h00, "l3_ld");
    for (int i = 0; i < 3; i++) cyc(1, alu(1, 1, 5, 0), 0, 1, 8'h20, $sformatf("l3_sub_stall%0d", i));
    cyc(1, alu(1, 1, 5, 0), 0, 0, 8'h00, "l3_sub_issue");
    cyc(0, 16'h0000, 0, 0, 8'h00, "l3_idle");

    // LOAD_LAT=3 with one independent instruction in between
    cyc(1, ld(2, 0), 0, 0, 8'h00, "gap_ld");
    cyc(1, {OPC_BR, 3'd2, 3'd2, 8'h00}, 0, 0, 8'h04, "gap_br");
    cyc(1, alu(0, 0, 2, 0), 0, 1, 8'h04, "gap_stall0");
    cyc(1, alu(0, 0, 2, 0), 0, 1, 8'h04, "gap_stall1");
    cyc(1, alu(0, 0, 2, 0), 0, 0, 8'h00, "gap_issue");

    // Decode variants against a pending r5
    cyc(1, ld(5, 0), 0, 0, 8'h00, "dec_ld");
    cyc(1, alu(7, 5, 5, 0), 0, 0, 8'h20, "dec_noread");
    cyc(1, alu(0, 5, 0, 1), 0, 0, 8'h20, "dec_imm_rb_only");
    cyc(1, alu(13, 5, 0, 0), 0, 1, 8'h20, "dec_out_ra");
    cyc(1, alu(13, 5, 0, 0), 0, 0, 8'h00, "dec_out_issue");

    // LOAD_LAT=2 load-on-load reload
    do_reset();
    sel = 2;
    cyc(1, ld(4, 0), 0, 0, 8'h00, "ll_ld1");
    cyc(1, ld(4, 4), 0, 1, 8'h10, "ll_ld2_stall0");
    cyc(1, ld(4, 4), 0, 1, 8'h10, "ll_ld2_stall1");
    cyc(1, ld(4, 4), 0, 0, 8'h00, "ll_ld2_issue");
    cyc(1, stw(4), 0, 1, 8'h10, "ll_st_stall0");
    cyc(1, stw(4), 0, 1, 8'h10, "ll_st_stall1");
    cyc(1, stw(4), 0, 0, 8'h00, "ll_st_issue");

    // Flushed / invalid instructions neither stall nor set
    do_reset();
    sel = 3;
    cyc(1, ld(1, 0), 0, 0, 8'h00, "fl_ld");
    cyc(1, stw(1), 1, 0, 8'h02, "fl_reader_flushed");
    cyc(1, ld(7, 1), 1, 0, 8'h02, "fl_ld_flushed");
    cyc(0, ld(7, 1), 0, 0, 8'h02, "fl_ld_invalid");
    cyc(0, 16'h0000, 0, 0, 8'h00, "fl_clear");

    // Reset mid-operation
    cyc(1, ld(6, 0), 0, 0, 8'h00, "mr_ld");
    cyc(1, alu(0, 0, 6, 0), 0, 1, 8'h40, "mr_stall");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, alu(0, 0, 6, 0), 0, 0, 8'h00, "mr_after_rst");

    // LOAD_LAT=0 never stalls
    do_reset();
    sel = 0;
    cyc(1, ld(3, 0), 0, 0, 8'h00, "l0_ld");
    cyc(1, alu(0, 3, 3, 0), 0, 0, 8'h00, "l0_reader");

    // Four LD-use pairs at LOAD_LAT=3
    do_reset();
    sel = 3;
    for (int p = 0; p < 4; p++) begin
      cyc(1, ld(5, 0), 0, 0, 8'h00, $sformatf("pp%0d_ld", p));
      for (int i = 0; i < 3; i++) cyc(1, alu(1, 1, 5, 0), 0, 1, 8'h20, $sformatf("pp%0d_stall%0d", p, i));
      cyc(1, alu(1, 1, 5, 0), 0, 0, 8'h00, $sformatf("pp%0d_issue", p));
    end
    cyc(0, 16'h0000, 0, 0, 8'h00, "pp_idle");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_count", pc[3], 32'd12);
    do_reset();
    chk("perf_clear", pc[3], 32'd0);
`endif

    if (q.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL scoreboard_drain: observed %0d entries expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
